// File: rtl/tx_rem_symbol_pack.sv
// tx_rem_symbol_pack
// Packs the serial transform-precoder output (one complex sample per cycle)
// into 12-subcarrier symbol vectors for the resource-element mapper, and
// inserts the DMRS pilot vector at PILOT_SYM within every slot. Output is a
// valid/ready stream with one vector per SC-FDMA symbol; slots run back to
// back after a single i_start.
// Optional feature macro: REM_PACK_SYM_CNT_EN adds o_sym_cnt, a 16-bit count
// of output transfers since reset.
module tx_rem_symbol_pack #(
  parameter int DATA_WIDTH   = 16,
  parameter int SYM_PER_SLOT = 7,
  parameter int PILOT_SYM    = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [2*DATA_WIDTH-1:0]  i_data,
  input  logic [24*DATA_WIDTH-1:0] i_pilot_seq,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [24*DATA_WIDTH-1:0] o_data,
  output logic                    o_pilot,
  output logic [2:0]              o_sym_idx
`ifdef REM_PACK_SYM_CNT_EN
  ,
  output logic [15:0]             o_sym_cnt
`endif
);

  localparam logic [2:0] LP_LAST_SYM  = 3'(SYM_PER_SLOT - 1);
  localparam logic [2:0] LP_PILOT_SYM = 3'(PILOT_SYM);
  localparam logic [3:0] LP_LAST_SC   = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_PILOT
  } state_t;

  state_t                                 r_state;
  state_t                                 w_state_nxt;
  logic [11:0][2*DATA_WIDTH-1:0]          r_fill_buf;
  logic [3:0]                             r_sc_cnt;
  logic [2:0]                             r_sym_idx;
  logic [2:0]                             w_sym_nxt;
  logic                                   r_valid;
  logic                                   r_pilot;
  logic [2:0]                             r_out_idx;
  logic [24*DATA_WIDTH-1:0]               r_data;
  logic                                   w_slot_free;
  logic                                   w_in_xfer;
  logic                                   w_out_xfer;

  // The output register may be (re)loaded when empty or being drained now.
  assign w_slot_free = !r_valid || i_ready;
  assign o_ready     = (r_state == S_FILL) && !i_start;
  assign w_in_xfer   = i_valid && o_ready;
  assign w_out_xfer  = r_valid && i_ready;
  assign w_sym_nxt   = (r_sym_idx == LP_LAST_SYM) ? 3'd0 : r_sym_idx + 3'd1;

  assign o_valid   = r_valid;
  assign o_pilot   = r_pilot;
  assign o_sym_idx = r_out_idx;
  assign o_data    = r_data;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; i_start overrides every other event.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = (LP_PILOT_SYM == 3'd0) ? S_PILOT : S_FILL;
    end else begin
      case (r_state)
        S_FILL:  if (w_in_xfer && (r_sc_cnt == LP_LAST_SC)) w_state_nxt = S_FULL;
        S_FULL:  if (w_slot_free) w_state_nxt = (w_sym_nxt == LP_PILOT_SYM) ? S_PILOT : S_FILL;
        S_PILOT: if (w_slot_free) w_state_nxt = S_FILL;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Fill buffer, counters and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the fill buffer is small and must read as zero after reset, so it is reset like any register.
      r_fill_buf <= '0;
      r_sc_cnt   <= '0;
      r_sym_idx  <= '0;
      r_valid    <= 1'b0;
      r_pilot    <= 1'b0;
      r_out_idx  <= '0;
      r_data     <= '0;
    end else if (i_start) begin
      r_sc_cnt  <= '0;
      r_sym_idx <= '0;
      r_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking; a later load in this block overrides this drain clear (last assignment wins).
      if (w_out_xfer) r_valid <= 1'b0;

      if ((r_state == S_FILL) && w_in_xfer) begin
        r_fill_buf[r_sc_cnt] <= i_data;
        r_sc_cnt             <= (r_sc_cnt == LP_LAST_SC) ? 4'd0 : r_sc_cnt + 4'd1;
      end

      if ((r_state == S_FULL) && w_slot_free) begin
        r_data    <= r_fill_buf;
        r_pilot   <= 1'b0;
        r_out_idx <= r_sym_idx;
        r_valid   <= 1'b1;
        r_sym_idx <= w_sym_nxt;
      end

      if ((r_state == S_PILOT) && w_slot_free) begin
        r_data    <= i_pilot_seq;
        r_pilot   <= 1'b1;
        r_out_idx <= r_sym_idx;
        r_valid   <= 1'b1;
        r_sym_idx <= w_sym_nxt;
      end
    end
  end

`ifdef REM_PACK_SYM_CNT_EN
  logic [15:0] r_sym_cnt;

  // Output-transfer counter; only reset clears it, wraps naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sym_cnt <= '0;
    end else if (w_out_xfer) begin
      r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign o_sym_cnt = r_sym_cnt;
`endif

endmodule

// File: tb/tb_tx_rem_symbol_pack.sv
// Bench for tx_rem_symbol_pack: directed stimulus, expected vectors pushed
// into a scoreboard queue when their last sample is accepted, and a monitor
// that pops and compares on every output transfer.
module tb_tx_rem_symbol_pack;

  localparam int SW     = 32;
  localparam int VW     = 384;
  localparam int N_SYM  = 7;
  localparam int PIL    = 3;
  localparam int BUDGET = 200;

  typedef struct {
    logic [VW-1:0] data;
    logic          pilot;
    logic [2:0]    idx;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [SW-1:0] i_data = '0;
  logic [VW-1:0] i_pilot_seq = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [VW-1:0] o_data;
  logic          o_pilot;
  logic [2:0]    o_sym_idx;
`ifdef REM_PACK_SYM_CNT_EN
  logic [15:0]   o_sym_cnt;
`endif

  tx_rem_symbol_pack dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_pilot_seq (i_pilot_seq),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_pilot     (o_pilot),
    .o_sym_idx   (o_sym_idx)
`ifdef REM_PACK_SYM_CNT_EN
    ,
    .o_sym_cnt   (o_sym_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      n_out    = 0;
  int      m_idx    = 0;
  exp_t    sb[$];
  logic [VW-1:0] pilot_vec;
  logic [VW-1:0] held_vec;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] samp(input int base, input int k);
    return {16'(base), 16'(k + 1)};
  endfunction

  function automatic int adv(input int idx);
    return (idx == N_SYM - 1) ? 0 : idx + 1;
  endfunction

  // Scoreboard monitor: compare every output transfer against the queue head.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", {381'd0, o_sym_idx}, {VW{1'b1}});
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", o_data, e.data);
        check("out_pilot", {383'd0, o_pilot}, {383'd0, e.pilot});
        check("out_sym_idx", {381'd0, o_sym_idx}, {381'd0, e.idx});
      end
    end
  end

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send_sample(input logic [SW-1:0] d);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    i_valid = 1'b1;
    i_data  = d;
    while (!acc && t < BUDGET) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      t++;
    end
    i_valid = 1'b0;
    if (!acc) check("send_timeout", 384'd0, 384'd1);
  endtask

  // Send n samples; a complete symbol pushes its expected vector (and a
  // following pilot vector when the model's slot index reaches PIL).
  task automatic send_sym(input int base, input int n, input bit push);
    exp_t e;
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      v[k*SW +: SW] = samp(base, k);
      send_sample(samp(base, k));
    end
    if (push && n == 12) begin
      e.data = v; e.pilot = 1'b0; e.idx = 3'(m_idx);
      sb.push_back(e);
      m_idx = adv(m_idx);
      if (m_idx == PIL) begin
        e.data = pilot_vec; e.pilot = 1'b1; e.idx = 3'(m_idx);
        sb.push_back(e);
        m_idx = adv(m_idx);
      end
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    check("start_blocks_ready", {383'd0, o_ready}, 384'd0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    m_idx = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < BUDGET) begin
      @(posedge i_clk);
      t++;
    end
    #1;
    check("drain", 384'(sb.size()), 384'd0);
  endtask

  initial begin
    for (int k = 0; k < 12; k++) pilot_vec[k*SW +: SW] = {16'hA5A5, 16'(k * 3 + 7)};
    i_pilot_seq = pilot_vec;

    // Reset values.
    #12;
    check("rst_valid", {383'd0, o_valid}, 384'd0);
    check("rst_pilot", {383'd0, o_pilot}, 384'd0);
    check("rst_sym_idx", {381'd0, o_sym_idx}, 384'd0);
    check("rst_data", o_data, 384'd0);
    check("rst_ready", {383'd0, o_ready}, 384'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("idle_ready", {383'd0, o_ready}, 384'd0);

    // Streaming: 12 data symbols -> two full slots with pilots at idx 3.
    i_ready = 1'b1;
    pulse_start();
    for (int s = 0; s < 12; s++) begin
      send_sym(s, 12, 1'b1);
      if (s == 0) begin
        @(negedge i_clk);
        check("lat_n1_valid", {383'd0, o_valid}, 384'd0);
        check("lat_n1_ready", {383'd0, o_ready}, 384'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("lat_n2_valid", {383'd0, o_valid}, 384'd1);
        @(posedge i_clk); #1;
      end
      if (s == 2) begin
        @(negedge i_clk);
        check("gap_full_ready", {383'd0, o_ready}, 384'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("gap_pilot_ready", {383'd0, o_ready}, 384'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("after_pilot_ready", {383'd0, o_ready}, 384'd1);
        check("after_pilot_flag", {383'd0, o_pilot}, 384'd1);
        @(posedge i_clk); #1;
      end
    end
    wait_drain();

    // Backpressure: first vector held while the next symbol fills and stalls.
    i_ready = 1'b0;
    pulse_start();
    send_sym(100, 12, 1'b1);
    held_vec = sb[0].data;
    send_sym(200, 12, 1'b1);
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      check("bp_ready", {383'd0, o_ready}, 384'd0);
      check("bp_valid", {383'd0, o_valid}, 384'd1);
      check("bp_data_hold", o_data, held_vec);
      check("bp_idx_hold", {381'd0, o_sym_idx}, 384'd0);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_drain();

    // Restart mid-fill: held vector and partial fill are discarded.
    i_ready = 1'b0;
    pulse_start();
    send_sym(300, 12, 1'b0);
    send_sym(400, 5, 1'b0);
    @(negedge i_clk);
    check("held_before_start", {383'd0, o_valid}, 384'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    pulse_start();
    i_valid = 1'b0;
    @(negedge i_clk);
    check("start_clears_valid", {383'd0, o_valid}, 384'd0);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send_sym(500, 12, 1'b1);
    send_sym(600, 12, 1'b1);
    wait_drain();

`ifdef REM_PACK_SYM_CNT_EN
    check("sym_cnt", 384'(o_sym_cnt), 384'(n_out));
`endif

    // Asynchronous reset mid-fill with a vector held at the output.
    i_ready = 1'b0;
    pulse_start();
    send_sym(700, 12, 1'b0);
    send_sym(800, 6, 1'b0);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", {383'd0, o_valid}, 384'd0);
    check("arst_pilot", {383'd0, o_pilot}, 384'd0);
    check("arst_sym_idx", {381'd0, o_sym_idx}, 384'd0);
    check("arst_data", o_data, 384'd0);
    check("arst_ready", {383'd0, o_ready}, 384'd0);
`ifdef REM_PACK_SYM_CNT_EN
    check("arst_sym_cnt", 384'(o_sym_cnt), 384'd0);
`endif
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("post_rst_idle_ready", {383'd0, o_ready}, 384'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
